// File: rtl/frac_bin_to_bcd.sv
// frac_bin_to_bcd: sequential converter from an unsigned binary fraction
// 0.b1b2..bN to DIGITS BCD digits. Each CONV cycle multiplies the remainder
// by ten, and the integer part that falls out is the next decimal digit.
// An optional ROUND cycle applies round-half-up using the next digit.
module frac_bin_to_bcd #(
    parameter int FRAC_W = 8,
    parameter int DIGITS = 4,
    parameter int ROUND  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FRAC_W-1:0]     in_frac,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_carry,
    output logic                  out_exact,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        RND   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [FRAC_W-1:0]     r_q, r_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  carry_q, carry_d;
    logic                  exact_q, exact_d;

    logic [FRAC_W+3:0]     r_ext_s;
    logic [FRAC_W+3:0]     p_s;
    logic [3:0]            digit_s;
    logic [4*DIGITS:0]     inc_s;

    // Shift a new digit into the least significant nibble; after DIGITS
    // shifts the first (tenths) digit sits in the most significant nibble.
    function automatic logic [4*DIGITS-1:0] shift_digit(
        input logic [4*DIGITS-1:0] v,
        input logic [3:0]          d
    );
        logic [4*DIGITS+3:0] tmp;
        tmp = {v, d};
        return tmp[4*DIGITS-1:0];
    endfunction

    // Decimal increment across all digits in one step; the MSB of the
    // result is the carry out of the tenths digit (value reached 1.0).
    function automatic logic [4*DIGITS:0] bcd_inc(
        input logic [4*DIGITS-1:0] v
    );
        logic [4*DIGITS-1:0] res;
        logic                c;
        res = v;
        c   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    res[4*i +: 4] = 4'd0;
                    c             = 1'b1;
                end else begin
                    res[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c             = 1'b0;
                end
            end else begin
                res[4*i +: 4] = v[4*i +: 4];
            end
        end
        return {c, res};
    endfunction

    // Remainder times ten as (r<<3)+(r<<1); its top nibble is the next digit.
    always_comb begin
        r_ext_s = {4'b0000, r_q};
        p_s     = (r_ext_s << 3) + (r_ext_s << 1);
        digit_s = p_s[FRAC_W+3:FRAC_W];
        inc_s   = bcd_inc(bcd_q);
    end

    // Next-state and datapath update for the conversion sequencer.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        exact_d = exact_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    r_d     = in_frac;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    exact_d = 1'b0;
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                r_d   = p_s[FRAC_W-1:0];
                bcd_d = shift_digit(bcd_q, digit_s);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    exact_d = (p_s[FRAC_W-1:0] == '0);
                    if (ROUND != 0) begin
                        state_d = RND;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = CONV;
                end
            end
            RND: begin
                // Next digit is >= 5 exactly when remainder >= 0.5.
                if (r_q[FRAC_W-1]) begin
                    bcd_d   = inc_s[4*DIGITS-1:0];
                    carry_d = inc_s[4*DIGITS];
                end else begin
                    bcd_d   = bcd_q;
                    carry_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            exact_q <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            exact_q <= exact_d;
        end
    end

    // Outputs decoded from registered state; only in_ready sees rst directly.
    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
        busy      = (state_q == CONV) || (state_q == RND);
        out_bcd   = bcd_q;
        out_carry = carry_q;
        out_exact = exact_q;
    end

endmodule

// File: tb/tb_frac_bin_to_bcd.sv
// Directed bench for frac_bin_to_bcd: six instances with different
// parameter sets share clock, reset and out_ready; a vector table drives them.
module tb_frac_bin_to_bcd;

    logic        clk;
    logic        rst;
    logic        out_ready;
    logic [7:0]  frac;
    logic [5:0]  in_valid;
    logic [5:0]  in_ready;
    logic [5:0]  out_valid;
    logic [5:0]  out_carry;
    logic [5:0]  out_exact;
    logic [5:0]  busy;
    logic [19:0] bcd [6];

    logic [15:0] bcd0, bcd2, bcd3, bcd4;
    logic [19:0] bcd1;
    logic [7:0]  bcd5;

    assign bcd[0] = {4'h0, bcd0};
    assign bcd[1] = bcd1;
    assign bcd[2] = {4'h0, bcd2};
    assign bcd[3] = {4'h0, bcd3};
    assign bcd[4] = {4'h0, bcd4};
    assign bcd[5] = {12'h000, bcd5};

    frac_bin_to_bcd #(.FRAC_W(5), .DIGITS(4), .ROUND(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_frac(frac[4:0]), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_bcd(bcd0), .out_carry(out_carry[0]), .out_exact(out_exact[0]), .busy(busy[0]));
    frac_bin_to_bcd #(.FRAC_W(5), .DIGITS(5), .ROUND(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_frac(frac[4:0]), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_bcd(bcd1), .out_carry(out_carry[1]), .out_exact(out_exact[1]), .busy(busy[1]));
    frac_bin_to_bcd #(.FRAC_W(5), .DIGITS(4), .ROUND(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_frac(frac[4:0]), .out_valid(out_valid[2]), .out_ready(out_ready),
        .out_bcd(bcd2), .out_carry(out_carry[2]), .out_exact(out_exact[2]), .busy(busy[2]));
    frac_bin_to_bcd #(.FRAC_W(8), .DIGITS(4), .ROUND(0)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_frac(frac), .out_valid(out_valid[3]), .out_ready(out_ready),
        .out_bcd(bcd3), .out_carry(out_carry[3]), .out_exact(out_exact[3]), .busy(busy[3]));
    frac_bin_to_bcd #(.FRAC_W(8), .DIGITS(4), .ROUND(1)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[4]), .in_ready(in_ready[4]),
        .in_frac(frac), .out_valid(out_valid[4]), .out_ready(out_ready),
        .out_bcd(bcd4), .out_carry(out_carry[4]), .out_exact(out_exact[4]), .busy(busy[4]));
    frac_bin_to_bcd #(.FRAC_W(8), .DIGITS(2), .ROUND(1)) u5 (
        .clk(clk), .rst(rst), .in_valid(in_valid[5]), .in_ready(in_ready[5]),
        .in_frac(frac), .out_valid(out_valid[5]), .out_ready(out_ready),
        .out_bcd(bcd5), .out_carry(out_carry[5]), .out_exact(out_exact[5]), .busy(busy[5]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        logic [7:0]  frac;
        logic [19:0] bcd;
        logic        carry;
        logic        exact;
        int          lat;
    } vec_t;

    vec_t vecs [13];
    int   n_vec;
    int   n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready, issue one request, then wait for out_valid.
    // Returns observed latency and number of busy cycles.
    task automatic issue_and_wait(input int inst, input logic [7:0] f,
                                  output int lat, output int bcnt);
        int w;
        w = 0;
        while (!in_ready[inst] && w < 50) begin
            tick();
            w++;
        end
        chk($sformatf("ready_before_accept[%0d]", inst), {31'd0, in_ready[inst]}, 32'd1);
        frac           = f;
        in_valid[inst] = 1'b1;
        tick();
        in_valid[inst] = 1'b0;
        frac           = 8'h00;
        lat  = 0;
        bcnt = 0;
        while (!out_valid[inst] && lat < 20) begin
            if (busy[inst]) bcnt++;
            tick();
            lat++;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat, bcnt;
        out_ready = 1'b1;
        issue_and_wait(v.inst, v.frac, lat, bcnt);
        chk($sformatf("v%0d_latency", idx), lat, v.lat);
        chk($sformatf("v%0d_busy_cycles", idx), bcnt, v.lat);
        chk($sformatf("v%0d_bcd", idx), {12'd0, bcd[v.inst]}, {12'd0, v.bcd});
        chk($sformatf("v%0d_carry", idx), {31'd0, out_carry[v.inst]}, {31'd0, v.carry});
        chk($sformatf("v%0d_exact", idx), {31'd0, out_exact[v.inst]}, {31'd0, v.exact});
        tick();
        chk($sformatf("v%0d_ready_after", idx), {31'd0, in_ready[v.inst]}, 32'd1);
        chk($sformatf("v%0d_valid_after", idx), {31'd0, out_valid[v.inst]}, 32'd0);
    endtask

    initial begin
        int lat, bcnt;
        n_vec = 0;
        n_bad = 0;
        vecs[0]  = '{0, 8'h05, 20'h01562, 1'b0, 1'b0, 4};
        vecs[1]  = '{1, 8'h05, 20'h15625, 1'b0, 1'b1, 5};
        vecs[2]  = '{2, 8'h05, 20'h01563, 1'b0, 1'b0, 5};
        vecs[3]  = '{3, 8'h80, 20'h05000, 1'b0, 1'b1, 4};
        vecs[4]  = '{3, 8'hFF, 20'h09960, 1'b0, 1'b0, 4};
        vecs[5]  = '{4, 8'hFF, 20'h09961, 1'b0, 1'b0, 5};
        vecs[6]  = '{3, 8'h01, 20'h00039, 1'b0, 1'b0, 4};
        vecs[7]  = '{4, 8'h01, 20'h00039, 1'b0, 1'b0, 5};
        vecs[8]  = '{5, 8'hFF, 20'h00000, 1'b1, 1'b0, 3};
        vecs[9]  = '{5, 8'h00, 20'h00000, 1'b0, 1'b1, 3};
        vecs[10] = '{4, 8'h80, 20'h05000, 1'b0, 1'b1, 5};
        vecs[11] = '{0, 8'h1F, 20'h09687, 1'b0, 1'b0, 4};
        vecs[12] = '{2, 8'h1F, 20'h09688, 1'b0, 1'b0, 5};

        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 6'd0;
        frac      = 8'h00;
        tick();
        tick();
        chk("reset_in_ready", {26'd0, in_ready}, 32'd0);
        chk("reset_out_valid", {26'd0, out_valid}, 32'd0);
        chk("reset_busy", {26'd0, busy}, 32'd0);
        chk("reset_carry", {26'd0, out_carry}, 32'd0);
        chk("reset_exact", {26'd0, out_exact}, 32'd0);
        chk("reset_bcd1", {12'd0, bcd[1]}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", {26'd0, in_ready}, 32'h3F);

        for (int i = 0; i < 13; i++) begin
            run_vec(i, vecs[i]);
        end

        // Backpressure with an ignored request while busy (8-bit, 4 digits, round).
        out_ready = 1'b0;
        frac      = 8'hFF;
        in_valid[4] = 1'b1;
        tick();
        in_valid[4] = 1'b0;
        tick();
        frac        = 8'h01;
        in_valid[4] = 1'b1;
        tick();
        in_valid[4] = 1'b0;
        frac        = 8'h00;
        lat = 0;
        while (!out_valid[4] && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_valid_rise", {31'd0, out_valid[4]}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_hold_bcd_%0d", i), {16'd0, bcd4}, 32'h9961);
            chk($sformatf("bp_hold_valid_%0d", i), {31'd0, out_valid[4]}, 32'd1);
            chk($sformatf("bp_hold_ready_%0d", i), {31'd0, in_ready[4]}, 32'd0);
            chk($sformatf("bp_hold_carry_%0d", i), {31'd0, out_carry[4]}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_ready", {31'd0, in_ready[4]}, 32'd1);
        chk("bp_release_valid", {31'd0, out_valid[4]}, 32'd0);

        // Reset during the second CONV cycle of instance 3.
        frac        = 8'h80;
        in_valid[3] = 1'b1;
        tick();
        in_valid[3] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready[3]}, 32'd1);
        chk("midrst_busy", {31'd0, busy[3]}, 32'd0);
        chk("midrst_valid", {31'd0, out_valid[3]}, 32'd0);
        chk("midrst_bcd", {16'd0, bcd3}, 32'd0);
        chk("midrst_exact", {31'd0, out_exact[3]}, 32'd0);
        issue_and_wait(3, 8'hFF, lat, bcnt);
        chk("midrst_new_latency", lat, 4);
        chk("midrst_new_bcd", {16'd0, bcd3}, 32'h9960);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
